// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl: multi-cycle sequencing FSM for the MIPS datapath.
// Splits each instruction into FETCH/DECODE/EXEC/MEM/WB steps and drives the
// per-state write enables and mux selects. Memory accesses (instruction fetch
// and data access) each take MEM_LAT cycles.
// Optional feature macro: MULTICYCLE_ILLEGAL_HALT_EN -- when defined, an
// unsupported instruction parks the controller in HALT until reset; otherwise
// it behaves as a nop that raises the illegal pulse.
module multicycle_ctrl #(
   parameter int MEM_LAT = 1
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [5:0] opcode,
   input  logic [5:0] funct,
   input  logic       zero,
   output logic [2:0] state,
   output logic       ir_we,
   output logic       pc_we,
   output logic [1:0] pc_sel,
   output logic       grf_we,
   output logic [1:0] grf_wa_sel,
   output logic [1:0] grf_wd_sel,
   output logic [2:0] alu_op,
   output logic       alu_src,
   output logic       ext_op,
   output logic [1:0] mem_size,
   output logic       load_sign,
   output logic       dm_we,
   output logic       instr_done,
   output logic       illegal
);

   typedef enum logic [2:0] {
      ST_FETCH  = 3'd0,
      ST_DECODE = 3'd1,
      ST_EXEC   = 3'd2,
      ST_MEM    = 3'd3,
      ST_WB     = 3'd4,
      ST_HALT   = 3'd5
   } state_e;

   localparam logic [3:0] LAST_CNT = 4'(MEM_LAT - 1);

   state_e     state_q, state_d;
   logic [3:0] cnt_q, cnt_d;
   logic       cntLast;

   logic isRtype, isAddu, isSubu, isJr, isNop;
   logic isOri, isLui, isBeq, isJ, isJal;
   logic isLw, isLb, isLbu, isLh, isLhu, isSw, isSb, isSh;
   logic isLoad, isStore, isLegal;

   logic [2:0] aluOpSel;
   logic       aluSrcSel, extOpSel;
   logic [1:0] memSizeSel;
   logic       loadSignSel;

   assign cntLast = (cnt_q == LAST_CNT);

   // Instruction classification straight from the IR fields
   always_comb begin
      isRtype = (opcode == 6'h00);
      isAddu  = isRtype && (funct == 6'h21);
      isSubu  = isRtype && (funct == 6'h23);
      isJr    = isRtype && (funct == 6'h08);
      isNop   = isRtype && (funct == 6'h00);
      isOri   = (opcode == 6'h0d);
      isLui   = (opcode == 6'h0f);
      isBeq   = (opcode == 6'h04);
      isJ     = (opcode == 6'h02);
      isJal   = (opcode == 6'h03);
      isLw    = (opcode == 6'h23);
      isLb    = (opcode == 6'h20);
      isLbu   = (opcode == 6'h24);
      isLh    = (opcode == 6'h21);
      isLhu   = (opcode == 6'h25);
      isSw    = (opcode == 6'h2b);
      isSb    = (opcode == 6'h28);
      isSh    = (opcode == 6'h29);
      isLoad  = isLw | isLb | isLbu | isLh | isLhu;
      isStore = isSw | isSb | isSh;
      isLegal = isAddu | isSubu | isJr | isNop | isOri | isLui | isBeq |
                isJ | isJal | isLoad | isStore;
   end

   // ALU and memory selects per instruction; EXEC/MEM drive them and WB holds them
   always_comb begin
      aluOpSel    = 3'd0;
      aluSrcSel   = 1'b0;
      extOpSel    = 1'b0;
      memSizeSel  = 2'd0;
      loadSignSel = 1'b0;
      if (isSubu) begin
         aluOpSel = 3'd1;
      end else if (isOri) begin
         aluOpSel  = 3'd2;
         aluSrcSel = 1'b1;
      end else if (isLui) begin
         aluOpSel  = 3'd3;
         aluSrcSel = 1'b1;
      end else if (isBeq) begin
         aluOpSel = 3'd1;
         extOpSel = 1'b1;
      end else if (isLoad || isStore) begin
         aluSrcSel = 1'b1;
         extOpSel  = 1'b1;
      end
      if (isLh || isLhu || isSh) begin
         memSizeSel = 2'd1;
      end else if (isLb || isLbu || isSb) begin
         memSizeSel = 2'd2;
      end
      loadSignSel = isLb | isLh;
   end

   // State and wait-counter registers, synchronous reset back to FETCH
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= ST_FETCH;
         cnt_q   <= 4'd0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   // Next-state logic; the counter only advances while waiting on memory and
   // is cleared whenever the state changes
   always_comb begin
      state_d = state_q;
      cnt_d   = 4'd0;
      case (state_q)
         ST_FETCH: begin
            if (cntLast) state_d = ST_DECODE;
            else         cnt_d   = cnt_q + 4'd1;
         end
         ST_DECODE: begin
            if (!isLegal) begin
`ifdef MULTICYCLE_ILLEGAL_HALT_EN
               state_d = ST_HALT;
`else
               state_d = ST_FETCH;
`endif
            end else if (isJ || isJal || isJr || isNop) begin
               state_d = ST_FETCH;
            end else begin
               state_d = ST_EXEC;
            end
         end
         ST_EXEC: begin
            if (isBeq)                   state_d = ST_FETCH;
            else if (isLoad || isStore)  state_d = ST_MEM;
            else                         state_d = ST_WB;
         end
         ST_MEM: begin
            if (cntLast) state_d = isStore ? ST_FETCH : ST_WB;
            else         cnt_d   = cnt_q + 4'd1;
         end
         ST_WB: state_d = ST_FETCH;
         ST_HALT: begin
`ifdef MULTICYCLE_ILLEGAL_HALT_EN
            state_d = ST_HALT;
`else
            state_d = ST_FETCH;
`endif
         end
         default: state_d = ST_FETCH;
      endcase
   end

   // Moore output decode; the IR is only valid from DECODE onward, so outputs
   // are decoded from the current state rather than pre-registered, and reset
   // forces every enable low so an aborted instruction writes nothing
   always_comb begin
      state      = state_q;
      ir_we      = 1'b0;
      pc_we      = 1'b0;
      pc_sel     = 2'd0;
      grf_we     = 1'b0;
      grf_wa_sel = 2'd0;
      grf_wd_sel = 2'd0;
      alu_op     = 3'd0;
      alu_src    = 1'b0;
      ext_op     = 1'b0;
      mem_size   = 2'd0;
      load_sign  = 1'b0;
      dm_we      = 1'b0;
      instr_done = 1'b0;
      illegal    = 1'b0;
      if (reset) begin
         state = ST_FETCH;
      end else begin
         case (state_q)
            ST_FETCH: begin
               if (cntLast) begin
                  ir_we = 1'b1;
                  pc_we = 1'b1;
               end
            end
            ST_DECODE: begin
               if (!isLegal) begin
                  illegal    = 1'b1;
                  instr_done = 1'b1;
               end else if (isJ || isJal) begin
                  pc_we      = 1'b1;
                  pc_sel     = 2'd2;
                  instr_done = 1'b1;
                  if (isJal) begin
                     grf_we     = 1'b1;
                     grf_wa_sel = 2'd2;
                     grf_wd_sel = 2'd2;
                  end
               end else if (isJr) begin
                  pc_we      = 1'b1;
                  pc_sel     = 2'd3;
                  instr_done = 1'b1;
               end else if (isNop) begin
                  instr_done = 1'b1;
               end
            end
            ST_EXEC: begin
               alu_op  = aluOpSel;
               alu_src = aluSrcSel;
               ext_op  = extOpSel;
               if (isBeq) begin
                  instr_done = 1'b1;
                  if (zero) begin
                     pc_we  = 1'b1;
                     pc_sel = 2'd1;
                  end
               end
            end
            ST_MEM: begin
               alu_op    = aluOpSel;
               alu_src   = aluSrcSel;
               ext_op    = extOpSel;
               mem_size  = memSizeSel;
               load_sign = loadSignSel;
               if (cntLast && isStore) begin
                  dm_we      = 1'b1;
                  instr_done = 1'b1;
               end
            end
            ST_WB: begin
               alu_op     = aluOpSel;
               alu_src    = aluSrcSel;
               ext_op     = extOpSel;
               grf_we     = 1'b1;
               grf_wa_sel = isRtype ? 2'd1 : 2'd0;
               grf_wd_sel = isLoad ? 2'd1 : 2'd0;
               instr_done = 1'b1;
               if (isLoad) begin
                  mem_size  = memSizeSel;
                  load_sign = loadSignSel;
               end
            end
            default: begin
            end
         endcase
      end
   end

endmodule

// File: doc/multicycle_ctrl.md
Name: multicycle_ctrl

Overview:
- Multi-cycle sequencing FSM for the MIPS datapath (IFU/PC, GRF, Extender, ALU, shared instruction/data memory).
- Replaces the single-cycle combinational Controller: one instruction is split into FETCH/DECODE/EXEC/MEM/WB steps.
- Drives per-state write enables and mux selects.
- Memory accesses wait a parameterised latency.

Parameters:
MEM_LAT, 1, cycles per memory access (fetch or data), legal range 1..15.

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
opcode  in  6  Instr[31:26] from the IR register; stable from DECODE onward
funct  in  6  Instr[5:0] from the IR register
zero  in  1  ALU result == 0 (beq compare)
state  out  3  0 FETCH, 1 DECODE, 2 EXEC, 3 MEM, 4 WB, 5 HALT
ir_we  out  1  latch the instruction register
pc_we  out  1  PC write
pc_sel  out  2  0 PC+4, 1 PC+(simm<<2), 2 {PC[31:28],imm26,00}, 3 rs
grf_we  out  1  register-file write
grf_wa_sel  out  2  0 rt, 1 rd, 2 $31
grf_wd_sel  out  2  0 ALU result, 1 memory data, 2 current PC (already +4)
alu_op  out  3  0 add, 1 sub, 2 or, 3 lui (B<<16)
alu_src  out  1  0 rt data, 1 extended immediate
ext_op  out  1  0 zero-extend, 1 sign-extend
mem_size  out  2  0 word, 1 half, 2 byte
load_sign  out  1  sign-extend sub-word load data
dm_we  out  1  data-memory write
instr_done  out  1  one-cycle pulse on the final cycle of each instruction
illegal  out  1  one-cycle pulse when an unsupported instruction is decoded

Behaviour:
- Supported instructions:
  - R-type: addu 0x21, subu 0x23, jr 0x08, nop (word 0).
  - I-type: ori 0x0d, lui 0x0f, beq 0x04, lw 0x23, lb 0x20, lbu 0x24, lh 0x21, lhu 0x25, sw 0x2b, sb 0x28, sh 0x29.
  - J-type: j 0x02, jal 0x03.
- Reset (synchronous): state=FETCH, wait counter=0, all enables and pulses 0, selects 0. Reset mid-instruction aborts with no GRF, DM or PC write in that cycle.
- Outputs are Moore functions of (state, counter, opcode, funct). Selects not listed for a state are 0.
- FETCH:
  - Counter runs 0..MEM_LAT-1.
  - On cnt==MEM_LAT-1: ir_we=1, pc_we=1, pc_sel=0, then go to DECODE and clear the counter.
- DECODE:
  - j: pc_we, pc_sel=2, done, go to FETCH.
  - jal: as j, plus grf_we, wa_sel=2, wd_sel=2.
  - jr: pc_we, pc_sel=3, done, go to FETCH.
  - nop: done, go to FETCH.
  - Unsupported: illegal=1, done, go to FETCH (treated as nop).
  - All others: go to EXEC.
- EXEC:
  - addu/subu: alu_op 0/1, alu_src=0, go to WB.
  - ori: alu_op 2, alu_src=1, ext_op=0, go to WB.
  - lui: alu_op 3, alu_src=1, go to WB.
  - beq: alu_op 1, ext_op=1. If zero: pc_we=1, pc_sel=1. Then done, go to FETCH.
  - Loads and stores: alu_op 0, alu_src=1, ext_op=1, go to MEM.
- MEM:
  - Address operands stay held (alu_op 0, alu_src 1, ext_op 1); mem_size and load_sign are valid for the whole state.
  - Counter runs 0..MEM_LAT-1.
  - Stores: dm_we=1 only on cnt==MEM_LAT-1 (exactly one cycle), done, go to FETCH.
  - Loads: go to WB on cnt==MEM_LAT-1.
- WB:
  - grf_we=1 for one cycle.
  - wa_sel: 1 for R-type, 0 otherwise.
  - wd_sel: 1 for loads, 0 otherwise.
  - done, go to FETCH.
  - The ALU/mem selects of the previous state are held in WB.
- Cycle counts: let L=MEM_LAT.
  - j/jal/jr/nop: L+1.
  - beq: L+2.
  - addu/ori/lui: L+3.
  - store: 2L+2.
  - load: 2L+3.
- The counter is 4 bits and is cleared on every state change. It never wraps, because MEM_LAT≤15.
- Undefined state codes (6,7) recover to FETCH on the next clock.

Optional Feature:
- Macro: MULTICYCLE_ILLEGAL_HALT_EN.
- When defined:
  - An unsupported opcode pulses illegal and enters HALT (state=5).
  - HALT is sticky until reset; all enables are 0 and instr_done=0.
- When undefined: an unsupported opcode is a nop (illegal pulse, back to FETCH), and HALT is unreachable.

Test Plan:
1. reset held 2 cycles, MEM_LAT=1 -> state=0, all enables 0. Release -> ir_we=pc_we=1 in the first cycle, state=1 next.
2. addu (op 0, funct 0x21), MEM_LAT=1 -> states 0,1,2,4. grf_we=1 with wa_sel=1, wd_sel=0 only in WB. instr_done on cycle 4.
3. lw (0x23), MEM_LAT=3 -> FETCH 3 cycles, DECODE, EXEC, MEM 3 cycles, WB (9 cycles). In WB: wd_sel=1, wa_sel=0, mem_size=0.
4. sb (0x28), MEM_LAT=2 -> dm_we high for exactly 1 cycle (second MEM cycle), mem_size=2, grf_we never asserted, 6 cycles total.
5. beq (0x04): zero=1 -> pc_we=1, pc_sel=1 in EXEC. zero=0 -> pc_we=0 in EXEC. jal (0x03) -> in DECODE: pc_sel=2, grf_we=1, wa_sel=2, wd_sel=2.
6. opcode 0x3f -> illegal pulse, back to FETCH. With MULTICYCLE_ILLEGAL_HALT_EN: state=5 held for 20 cycles with no enables, then reset returns to state=0.
